// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its wait-state timer.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Student-record register slave map
   localparam logic [APB_ADDR_W-1:0] REG_NUM     = 32'h0000_0000;
   localparam logic [APB_ADDR_W-1:0] REG_DATE    = 32'h0000_0004;
   localparam logic [APB_ADDR_W-1:0] REG_SURNAME = 32'h0000_0008;
   localparam logic [APB_ADDR_W-1:0] REG_NAME    = 32'h0000_000C;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      ERR    = 2'd3
   } apb_state_t;

   // Registers are 32-bit words, so the two low address bits must be zero.
   function automatic logic is_word_aligned(input logic [APB_ADDR_W-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts stalled ACCESS cycles and flags the cycle on which the transfer must be abandoned.
module apb_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q;

   // Wait counter: cleared during SETUP, advances on each stalled ACCESS cycle, saturates at the limit
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q != CNT_MAX)) begin
         count_q <= count_q + CNT_W'(1);
      end else begin
         count_q <= count_q;
      end
   end

   // High while the current stalled cycle is the last one allowed
   assign expired_o = (count_q == CNT_LAST);

endmodule

// File: rtl/apb_master_seq.sv
// APB requester: takes one command at a time, runs a SETUP/ACCESS transfer, returns a response.
module apb_master_seq
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter bit ALIGN_CHECK    = 1'b1
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [APB_ADDR_W-1:0] cmd_addr,
   input  logic [APB_DATA_W-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [APB_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [APB_ADDR_W-1:0] PADDR,
   output logic [APB_DATA_W-1:0] PWDATA,
   input  logic [APB_DATA_W-1:0] PRDATA,
   input  logic                  PREADY
);

   apb_state_t            state_q;
   logic                  psel_q;
   logic                  penable_q;
   logic                  pwrite_q;
   logic [APB_ADDR_W-1:0] paddr_q;
   logic [APB_DATA_W-1:0] pwdata_q;
   logic                  rsp_valid_q;
   logic [APB_DATA_W-1:0] rsp_rdata_q;
   logic                  rsp_error_q;

   logic accept_s;
   logic misaligned_s;
   logic timer_clear_s;
   logic timer_enable_s;
   logic timer_expired_s;

   // A new command is only taken when idle and the previous response has been consumed
   assign cmd_ready      = (state_q == IDLE) && !rsp_valid_q;
   assign accept_s       = cmd_valid && cmd_ready;
   assign misaligned_s   = ALIGN_CHECK && !is_word_aligned(cmd_addr);
   assign timer_clear_s  = (state_q == SETUP);
   assign timer_enable_s = (state_q == ACCESS) && !PREADY;

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk_i     (PCLK),
      .rst_i     (PRESET),
      .clear_i   (timer_clear_s),
      .enable_i  (timer_enable_s),
      .expired_o (timer_expired_s)
   );

   // Transfer FSM driving the APB signals and the response register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rsp_valid_q && rsp_ready) begin
                  rsp_valid_q <= 1'b0;
               end
               if (accept_s) begin
                  if (misaligned_s) begin
                     // No bus cycle for an address the slave cannot decode
                     state_q <= ERR;
                  end else begin
                     state_q   <= SETUP;
                     psel_q    <= 1'b1;
                     penable_q <= 1'b0;
                     pwrite_q  <= cmd_write;
                     paddr_q   <= cmd_addr;
                     pwdata_q  <= cmd_wdata;
                  end
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: begin
               if (PREADY) begin
                  state_q     <= IDLE;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b0;
                  rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
               end else if (timer_expired_s) begin
                  state_q     <= IDLE;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b1;
                  rsp_rdata_q <= '0;
               end
            end
            ERR: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b1;
               rsp_error_q <= 1'b1;
               rsp_rdata_q <= '0;
            end
            default: begin
               state_q   <= IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_master_seq.sv
// Directed bench for apb_master_seq with a behavioural student-record APB slave.
module tb_apb_master_seq;
   import apb_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY;
   logic [31:0] PADDR, PWDATA, PRDATA;

   // slave model controls
   int          wait_cfg;
   logic        force_nready;
   logic        spurious;
   int          wcnt;
   logic [31:0] regs [4];

   int checks = 0;
   int errors = 0;
   int psel_cnt = 0;
   int pen_cnt = 0;

   apb_master_seq dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   assign PREADY = spurious ||
                   (PSEL && PENABLE && !force_nready && (wcnt == wait_cfg));
   assign PRDATA = regs[PADDR[3:2]];

   // slave: wait-state counting and register writes
   always @(posedge PCLK) begin
      if (PSEL && PENABLE) begin
         if (PREADY) begin
            wcnt <= 0;
            if (PWRITE) regs[PADDR[3:2]] <= PWDATA;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   // bus activity monitor: cycles with PSEL / PENABLE high
   always @(posedge PCLK) begin
      if (PSEL)    psel_cnt <= psel_cnt + 1;
      if (PENABLE) pen_cnt  <= pen_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   // present a command until accepted (bounded); returns at the negedge after the accept edge
   task automatic issue(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
      logic ok;
      ok = 1'b0;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      for (int n = 0; n < 20 && !ok; n++) begin
         ok = cmd_ready;
         tick();
      end
      cmd_valid = 1'b0;
      chk({tag, "_accept"}, {31'd0, ok}, 32'd1);
   endtask

   // count edges until rsp_valid, bounded; result is accept-to-response latency in edges
   task automatic wait_rsp(input int max_edges, output int lat);
      int e;
      e = 0;
      while (!rsp_valid && e < max_edges) begin
         tick();
         e++;
      end
      lat = e + 1;
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   int lat, p0, e0_cnt;
   logic stable;
   logic [31:0] r0;
   logic        er0;

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
      rsp_ready = 1'b0; wait_cfg = 0; force_nready = 1'b0; spurious = 1'b0;
      for (int i = 0; i < 4; i++) regs[i] = 32'd0;
      tick(); tick();
      PRESET = 1'b0;
      tick();

      // reset state
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_psel",      {31'd0, PSEL}, 32'd0);
      chk("rst_penable",   {31'd0, PENABLE}, 32'd0);
      chk("rst_pwrite",    {31'd0, PWRITE}, 32'd0);
      chk("rst_paddr",     PADDR, 32'd0);
      chk("rst_pwdata",    PWDATA, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);

      // 1: write 7 to 0x0 with one wait state
      wait_cfg = 1;
      p0 = psel_cnt; e0_cnt = pen_cnt;
      issue("t1", 1'b1, REG_NUM, 32'h0000_0007);
      chk("t1_pwdata", PWDATA, 32'h0000_0007);
      chk("t1_setup_psel", {31'd0, PSEL}, 32'd1);
      chk("t1_setup_penable", {31'd0, PENABLE}, 32'd0);
      wait_rsp(40, lat);
      chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t1_latency", 32'(lat), 32'd4);
      chk("t1_rsp_error", {31'd0, rsp_error}, 32'd0);
      chk("t1_rsp_rdata", rsp_rdata, 32'd0);
      chk("t1_psel_cycles", 32'(psel_cnt - p0), 32'd3);
      chk("t1_penable_cycles", 32'(pen_cnt - e0_cnt), 32'd2);
      consume();
      chk("t1_slave_reg", regs[0], 32'h0000_0007);

      // 2: write then read 0x4, zero wait states
      wait_cfg = 0;
      issue("t2w", 1'b1, REG_DATE, 32'h1503_2024);
      wait_rsp(40, lat);
      chk("t2w_latency", 32'(lat), 32'd3);
      chk("t2w_rsp_error", {31'd0, rsp_error}, 32'd0);
      consume();
      issue("t2r", 1'b0, REG_DATE, 32'hDEAD_BEEF);
      wait_rsp(40, lat);
      chk("t2r_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t2r_latency", 32'(lat), 32'd3);
      chk("t2r_rsp_rdata", rsp_rdata, 32'h1503_2024);
      chk("t2r_rsp_error", {31'd0, rsp_error}, 32'd0);
      consume();
      chk("t2_paddr_hold", PADDR, REG_DATE);
      chk("t2_pwrite_hold", {31'd0, PWRITE}, 32'd0);

      // 3: PREADY held low, read 0x8 times out after 16 ACCESS cycles
      regs[2] = 32'hCAFE_F00D;
      force_nready = 1'b1;
      e0_cnt = pen_cnt;
      issue("t3", 1'b0, REG_SURNAME, 32'd0);
      wait_rsp(60, lat);
      chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_latency", 32'(lat), 32'd18);
      chk("t3_access_cycles", 32'(pen_cnt - e0_cnt), 32'd16);
      chk("t3_psel", {31'd0, PSEL}, 32'd0);
      chk("t3_penable", {31'd0, PENABLE}, 32'd0);
      chk("t3_rsp_error", {31'd0, rsp_error}, 32'd1);
      chk("t3_rsp_rdata", rsp_rdata, 32'd0);
      consume();
      force_nready = 1'b0;
      spurious = 1'b1;
      tick(); tick();
      spurious = 1'b0;
      tick();
      chk("t3_no_spurious_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("t3_spurious_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // 4: misaligned address 0x6
      p0 = psel_cnt;
      issue("t4", 1'b1, 32'h0000_0006, 32'h1234_5678);
      chk("t4_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
      wait_rsp(10, lat);
      chk("t4_latency", 32'(lat), 32'd2);
      chk("t4_rsp_error", {31'd0, rsp_error}, 32'd1);
      chk("t4_rsp_rdata", rsp_rdata, 32'd0);
      chk("t4_psel_never", 32'(psel_cnt - p0), 32'd0);
      consume();

      // 5: response backpressure for 5 cycles after a read
      issue("t5r", 1'b0, REG_DATE, 32'd0);
      wait_rsp(40, lat);
      chk("t5_rsp_rdata", rsp_rdata, 32'h1503_2024);
      r0 = rsp_rdata; er0 = rsp_error; stable = 1'b1;
      cmd_write = 1'b1; cmd_addr = REG_NAME; cmd_wdata = 32'hA5A5_0001; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         stable &= (rsp_rdata === r0) && (rsp_error === er0) && (rsp_valid === 1'b1)
                   && (cmd_ready === 1'b0) && (PSEL === 1'b0);
         tick();
      end
      chk("t5_stall_stable", {31'd0, stable}, 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t5_rsp_consumed", {31'd0, rsp_valid}, 32'd0);
      chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("t5_next_accept_psel", {31'd0, PSEL}, 32'd1);
      chk("t5_next_paddr", PADDR, REG_NAME);
      wait_rsp(40, lat);
      chk("t5w_rsp_error", {31'd0, rsp_error}, 32'd0);
      consume();
      chk("t5_slave_reg", regs[3], 32'hA5A5_0001);

      // 6: reset asserted during ACCESS
      force_nready = 1'b1;
      issue("t6a", 1'b0, REG_NUM, 32'd0);
      tick();
      chk("t6_in_access", {31'd0, PENABLE}, 32'd1);
      PRESET = 1'b1;
      #1;
      chk("t6_rst_psel", {31'd0, PSEL}, 32'd0);
      chk("t6_rst_penable", {31'd0, PENABLE}, 32'd0);
      chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge PCLK);
      PRESET = 1'b0;
      force_nready = 1'b0;
      wait_cfg = 1;
      tick();
      chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      issue("t6w", 1'b1, REG_SURNAME, 32'h0000_0055);
      wait_rsp(40, lat);
      chk("t6w_latency", 32'(lat), 32'd4);
      chk("t6w_rsp_error", {31'd0, rsp_error}, 32'd0);
      consume();
      chk("t6_slave_reg", regs[2], 32'h0000_0055);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
